// File: rtl/g07_slave_responder.sv
// Slave responder for the g07 arbitrated bus: single-word read/write into local storage
// after WAIT_STATES wait cycles, then a one-cycle Tdone pulse. Optional decode-error reporting: G07_SLAVE_ERR_EN.
module g07_slave_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'hfffe7637,
  parameter int          DEPTH       = 13,
  parameter int          WAIT_STATES = 2
) (
  input  logic        sysClk,
  input  logic        Breset,
  input  logic        en,
  input  logic [63:0] addr,
  input  logic        wr,
  input  logic [63:0] SbusIn,
  output logic [63:0] dbus_out,
  output logic        Tdone,
  output logic        busy,
  output logic        err
);

  localparam int                 DATA_W   = 64;
  localparam int                 IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]         WS       = 4'(WAIT_STATES);
  localparam logic [DATA_W-1:0]  ERR_WORD = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RECOVER} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               wr_p0;
  logic [DATA_W-1:0]  data_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [DATA_W-1:0]  mem [DEPTH] = '{default: '0};

  logic               idle;
  logic               go_done;
  logic               cur_wr;
  logic               cur_err;
  logic [DATA_W-1:0]  cur_data;
  logic [IDX_W-1:0]   cur_idx;

  // Out-of-window offsets wrap on the low index bits, then fold into 0..DEPTH-1.
  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE_ADDR) & 64'((64'd1 << IDX_W) - 64'd1);
    return IDX_W'(off % 64'(DEPTH));
  endfunction

`ifdef G07_SLAVE_ERR_EN
  logic err_p0;

  function automatic logic decode_err(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || (off >= 64'(DEPTH));
  endfunction
`endif

  // Accepting with zero wait states completes on the accept edge itself, so use the live bus.
  always_comb begin
    idle     = (state == S_IDLE);
    go_done  = (idle && en && (WS == 4'd0)) || (state == S_WAIT && en && cnt == 4'd1);
    cur_wr   = idle ? wr     : wr_p0;
    cur_data = idle ? SbusIn : data_p0;
    cur_idx  = idle ? word_idx(addr) : idx_p0;
`ifdef G07_SLAVE_ERR_EN
    cur_err  = idle ? decode_err(addr) : err_p0;
`else
    cur_err  = 1'b0;
`endif
  end

  always_ff @(posedge sysClk) begin
    if (idle && en) begin
      data_p0 <= SbusIn;
      idx_p0  <= word_idx(addr);
    end
  end

  always_ff @(posedge sysClk) begin
    if (!Breset && go_done && cur_wr && !cur_err)
      mem[cur_idx] <= cur_data;
  end

  always_ff @(posedge sysClk) begin
    if (Breset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      Tdone    <= 1'b0;
      dbus_out <= '0;
      wr_p0    <= 1'b0;
`ifdef G07_SLAVE_ERR_EN
      err      <= 1'b0;
      err_p0   <= 1'b0;
`endif
    end else begin
      Tdone <= go_done;
`ifdef G07_SLAVE_ERR_EN
      err   <= go_done && cur_err;
`endif
      if (go_done)
        dbus_out <= cur_err ? ERR_WORD : (cur_wr ? cur_data : mem[cur_idx]);
      case (state)
        S_IDLE: begin
          if (en) begin
            wr_p0  <= wr;
`ifdef G07_SLAVE_ERR_EN
            err_p0 <= decode_err(addr);
`endif
            cnt    <= WS;
            busy   <= 1'b1;
            state  <= (WS == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
              state <= S_DONE;
          end
        end
        S_DONE: state <= S_RECOVER;
        S_RECOVER: begin
          if (!en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef G07_SLAVE_ERR_EN
  assign err = 1'b0;
`endif

endmodule
